// File: rtl/fm_coord_gen_pkg.sv
// Shared widths and FSM encodings for the feature-map coordinate generator.
`timescale 1ns/1ps
package fm_coord_gen_pkg;

    localparam int X_COORD_WIDTH = 5;
    localparam int Y_COORD_WIDTH = 5;
    localparam int STRIDE_WIDTH  = 2;

    typedef enum logic [1:0] {
        FMCG_IDLE = 2'd0,
        FMCG_RUN  = 2'd1,
        FMCG_DONE = 2'd2
    } fmcg_state_e;

endpackage

// File: rtl/fm_axis_counter.sv
// Single-axis coordinate counter: load-zero, step-by-stride, and a widened
// "next step would pass the last index" flag that cannot be fooled by wrap.
`timescale 1ns/1ps
module fm_axis_counter #(
    parameter int W  = 5,
    parameter int SW = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          clear,
    input  logic          step,
    input  logic [W-1:0]  cfg_last,
    input  logic [SW-1:0] cfg_stride,
    output logic [W-1:0]  coord,
    output logic          next_exceeds
);

    logic [W-1:0]  coord_q, coord_d;
    logic [W-1:0]  last_q, last_d;
    logic [SW-1:0] stride_q, stride_d;
    logic [W:0]    next_wide;

    always_comb begin
        // One extra bit so x_last = all-ones still terminates cleanly.
        next_wide    = {1'b0, coord_q} + (W+1)'(stride_q);
        next_exceeds = next_wide > {1'b0, last_q};

        coord_d  = coord_q;
        last_d   = last_q;
        stride_d = stride_q;
        if (load) begin
            coord_d  = '0;
            last_d   = cfg_last;
            stride_d = cfg_stride;
        end else if (clear) begin
            coord_d = '0;
        end else if (step) begin
            coord_d = next_wide[W-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            coord_q  <= '0;
            last_q   <= '0;
            stride_q <= '0;
        end else begin
            coord_q  <= coord_d;
            last_q   <= last_d;
            stride_q <= stride_d;
        end
    end

    assign coord = coord_q;

endmodule

// File: rtl/fm_coord_gen.sv
// Raster-scan (x, y) coordinate generator with valid/ready output, stride and
// row/frame-end flags; holds the FSM and handshake around two axis counters.
`timescale 1ns/1ps
module fm_coord_gen
    import fm_coord_gen_pkg::*;
#(
    parameter int X_W  = X_COORD_WIDTH,
    parameter int Y_W  = Y_COORD_WIDTH,
    parameter int S_W  = STRIDE_WIDTH
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [X_W-1:0] cfg_x_last,
    input  logic [Y_W-1:0] cfg_y_last,
    input  logic [S_W-1:0] cfg_stride,
    input  logic           coord_ready,
    output logic           coord_valid,
    output logic [X_W-1:0] x_coord,
    output logic [Y_W-1:0] y_coord,
    output logic           row_last,
    output logic           frame_last,
    output logic           busy,
    output logic           done
);

    fmcg_state_e    state_q, state_d;
    logic           accept;
    logic           cfg_load;
    logic           x_step, x_clear, y_step, y_clear;
    logic           x_exceeds, y_exceeds;
    logic [S_W-1:0] stride_eff;

    assign stride_eff = (cfg_stride == '0) ? S_W'(1) : cfg_stride;

    fm_axis_counter #(.W(X_W), .SW(S_W)) u_x_cnt (
        .clock        (clock),
        .reset        (reset),
        .load         (cfg_load),
        .clear        (x_clear),
        .step         (x_step),
        .cfg_last     (cfg_x_last),
        .cfg_stride   (stride_eff),
        .coord        (x_coord),
        .next_exceeds (x_exceeds)
    );

    fm_axis_counter #(.W(Y_W), .SW(S_W)) u_y_cnt (
        .clock        (clock),
        .reset        (reset),
        .load         (cfg_load),
        .clear        (y_clear),
        .step         (y_step),
        .cfg_last     (cfg_y_last),
        .cfg_stride   (stride_eff),
        .coord        (y_coord),
        .next_exceeds (y_exceeds)
    );

    assign coord_valid = (state_q == FMCG_RUN);
    assign busy        = (state_q != FMCG_IDLE);
    assign done        = (state_q == FMCG_DONE);
    assign row_last    = coord_valid && x_exceeds;
    assign frame_last  = row_last && y_exceeds;
    assign accept      = coord_valid && coord_ready;

    always_comb begin
        state_d  = state_q;
        cfg_load = 1'b0;
        x_step   = 1'b0;
        x_clear  = 1'b0;
        y_step   = 1'b0;
        y_clear  = 1'b0;
        case (state_q)
            FMCG_IDLE: begin
                if (start) begin
                    cfg_load = 1'b1;
                    state_d  = FMCG_RUN;
                end
            end
            FMCG_RUN: begin
                if (accept) begin
                    if (!row_last) begin
                        x_step = 1'b1;
                    end else if (!frame_last) begin
                        x_clear = 1'b1;
                        y_step  = 1'b1;
                    end else begin
                        // Park both axes at zero so the idle outputs are clean.
                        x_clear = 1'b1;
                        y_clear = 1'b1;
                        state_d = FMCG_DONE;
                    end
                end
            end
            FMCG_DONE: begin
                state_d = FMCG_IDLE;
            end
            default: begin
                state_d = FMCG_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FMCG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_fm_coord_gen.sv
// Scoreboard bench for fm_coord_gen: stimulus queues expected beats, a
// negedge monitor pops and compares on every accepted handshake.
`timescale 1ns/1ps
module tb_fm_coord_gen;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       coord_ready = 1'b0;
    logic [4:0] cfg_x_last = '0;
    logic [4:0] cfg_y_last = '0;
    logic [1:0] cfg_stride = '0;
    logic       coord_valid, row_last, frame_last, busy, done;
    logic [4:0] x_coord, y_coord;

    always #5 clock = ~clock;

    fm_coord_gen dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .cfg_x_last  (cfg_x_last),
        .cfg_y_last  (cfg_y_last),
        .cfg_stride  (cfg_stride),
        .coord_ready (coord_ready),
        .coord_valid (coord_valid),
        .x_coord     (x_coord),
        .y_coord     (y_coord),
        .row_last    (row_last),
        .frame_last  (frame_last),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        int x;
        int y;
        bit rl;
        bit fl;
    } beat_t;

    beat_t sb_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    beats_seen  = 0;
    int    done_count  = 0;
    bit    hold_v      = 1'b0;
    bit    pend_done   = 1'b0;
    int    hx, hy, hrl, hfl;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard consumer
    always @(negedge clock) begin
        if (reset) begin
            hold_v    = 1'b0;
            pend_done = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", int'(coord_valid), 1);
                chk("hold_x", int'(x_coord), hx);
                chk("hold_y", int'(y_coord), hy);
                chk("hold_row_last", int'(row_last), hrl);
                chk("hold_frame_last", int'(frame_last), hfl);
                hold_v = 1'b0;
            end
            if (pend_done) begin
                chk("done_pulse", int'(done), 1);
                chk("done_busy", int'(busy), 1);
                chk("done_valid_low", int'(coord_valid), 0);
                pend_done = 1'b0;
            end else begin
                chk("no_spurious_done", int'(done), 0);
            end
            if (done) done_count++;
            if (coord_valid && coord_ready) begin
                beats_seen++;
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL beat_unexpected: got (%0d,%0d), expected no beat", x_coord, y_coord);
                end else begin
                    beat_t e;
                    e = sb_q.pop_front();
                    chk("beat_x", int'(x_coord), e.x);
                    chk("beat_y", int'(y_coord), e.y);
                    chk("beat_row_last", int'(row_last), int'(e.rl));
                    chk("beat_frame_last", int'(frame_last), int'(e.fl));
                    pend_done = e.fl;
                end
            end else if (coord_valid) begin
                hold_v = 1'b1;
                hx  = int'(x_coord);
                hy  = int'(y_coord);
                hrl = int'(row_last);
                hfl = int'(frame_last);
            end
        end
    end

    task automatic push_frame(input int xl, input int yl, input int st);
        int se;
        se = (st == 0) ? 1 : st;
        for (int y = 0; y <= yl; y += se) begin
            for (int x = 0; x <= xl; x += se) begin
                beat_t b;
                b.x  = x;
                b.y  = y;
                b.rl = (x + se > xl);
                b.fl = b.rl && (y + se > yl);
                sb_q.push_back(b);
            end
        end
    endtask

    task automatic issue_start(input int xl, input int yl, input int st, input bit rnd);
        @(posedge clock); #1;
        cfg_x_last  = 5'(xl);
        cfg_y_last  = 5'(yl);
        cfg_stride  = 2'(st);
        start       = 1'b1;
        coord_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clock); #1;
        start      = 1'b0;
        cfg_x_last = 5'd1;
        cfg_y_last = 5'd1;
        cfg_stride = 2'd3;
        chk("first_valid", int'(coord_valid), 1);
        chk("first_busy", int'(busy), 1);
        chk("first_x", int'(x_coord), 0);
        chk("first_y", int'(y_coord), 0);
    endtask

    task automatic run_frame(input int xl, input int yl, input int st,
                             input int exp_beats, input bit rnd, input bit glitch);
        int b0, d0, cyc;
        b0  = beats_seen;
        d0  = done_count;
        cyc = 0;
        push_frame(xl, yl, st);
        issue_start(xl, yl, st, rnd);
        while (done_count == d0 && cyc < 3000) begin
            coord_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start       = (glitch && (cyc == 3 || done)) ? 1'b1 : 1'b0;
            @(posedge clock); #1;
            cyc++;
        end
        start = 1'b0;
        chk("frame_done_count", done_count - d0, 1);
        chk("frame_beat_count", beats_seen - b0, exp_beats);
        chk("frame_sb_empty", sb_q.size(), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_valid", int'(coord_valid), 0);
        @(posedge clock); #1;
        chk("idle_valid_2", int'(coord_valid), 0);
        chk("idle_busy_2", int'(busy), 0);
        sb_q.delete();
    endtask

    initial begin
        int b0, d0, cyc;
        #12;
        chk("rst_valid", int'(coord_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_x", int'(x_coord), 0);
        chk("rst_y", int'(y_coord), 0);
        chk("rst_row_last", int'(row_last), 0);
        chk("rst_frame_last", int'(frame_last), 0);
        @(posedge clock); #1;
        reset = 1'b0;

        run_frame(3, 2, 1, 12, 1'b0, 1'b0);     // basic
        run_frame(5, 4, 2, 9, 1'b0, 1'b0);      // stride 2
        run_frame(7, 7, 3, 9, 1'b0, 1'b0);      // stride 3
        run_frame(3, 2, 0, 12, 1'b0, 1'b0);     // stride 0 acts as 1
        run_frame(3, 2, 1, 12, 1'b1, 1'b0);     // random backpressure
        run_frame(4, 3, 2, 6, 1'b1, 1'b0);      // backpressure with stride
        run_frame(0, 0, 1, 1, 1'b0, 1'b0);      // degenerate
        run_frame(31, 31, 1, 1024, 1'b0, 1'b0); // maximum
        run_frame(3, 2, 1, 12, 1'b0, 1'b1);     // start while busy

        // Reset in the middle of a scan
        b0  = beats_seen;
        cyc = 0;
        push_frame(3, 2, 1);
        issue_start(3, 2, 1, 1'b0);
        while (beats_seen < b0 + 5 && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk("pre_reset_beats", int'(beats_seen - b0 >= 5), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", int'(coord_valid), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_x", int'(x_coord), 0);
        chk("async_rst_y", int'(y_coord), 0);
        sb_q.delete();
        #8;
        reset = 1'b0;
        d0 = done_count;
        repeat (6) @(posedge clock);
        #1;
        chk("no_done_after_reset", done_count - d0, 0);
        chk("idle_after_reset", int'(busy), 0);
        run_frame(3, 2, 1, 12, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
